// File: rtl/fft_pkg.sv
// fft_pkg: shared FFT defaults and bit-reverse loader state encoding
package fft_pkg;
    localparam int BIT_WIDTH = 29;
    localparam int IN_WIDTH  = 16;
    localparam int FFT_N     = 16;
    localparam int FFT_SIZE  = 4;
    typedef enum logic [1:0] {IDLE, LOAD, WAIT_FFT} loader_state_t;
endpackage

// File: rtl/bit_reverse.sv
// bit_reverse: combinational W-bit reversal (q[i] = d[W-1-i])
//   d : input  W  value to reverse
//   q : output W  reversed value
module bit_reverse #(
    parameter int W = 4
) (
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    for (genvar i = 0; i < W; i++) begin : g_rev
        assign q[i] = d[W-1-i];
    end
endmodule

// File: rtl/bitrev_loader.sv
// bitrev_loader: loads N-sample frames into FFT RAM at bit-reversed addresses
//   clk, rst_n          : clock, async active-low reset
//   in_valid/in_ready   : sample handshake; in_re/in_im signed samples
//   fft_done            : FFT finished with RAM, next frame may load
//   load_data           : RAM write strobe; invert_adr/Re_i1/Im_i1 write data
//   busy                : frame in progress or awaiting FFT
//   frame_err           : pulse when a frame is aborted by an in_valid gap
module bitrev_loader
    import fft_pkg::*;
#(
    parameter int bit_width = BIT_WIDTH,
    parameter int in_width  = IN_WIDTH,
    parameter int N         = FFT_N,
    parameter int SIZE      = FFT_SIZE
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    input  logic signed [in_width-1:0]  in_re,
    input  logic signed [in_width-1:0]  in_im,
    output logic                        in_ready,
    input  logic                        fft_done,
    output logic                        load_data,
    output logic [SIZE:0]               invert_adr,
    output logic signed [bit_width-1:0] Re_i1,
    output logic signed [bit_width-1:0] Im_i1,
    output logic                        busy,
    output logic                        frame_err
);
    loader_state_t   state;
    logic [SIZE-1:0] cnt;
    logic [SIZE-1:0] rev;
    logic            accept;
    // cnt is always 0 outside LOAD, so it doubles as the write index in IDLE
    bit_reverse #(.W(SIZE)) u_rev (.d(cnt), .q(rev));
    assign in_ready = state != WAIT_FFT;
    assign accept   = in_valid && in_ready;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            load_data  <= 1'b0;
            invert_adr <= '0;
            Re_i1      <= '0;
            Im_i1      <= '0;
            busy       <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            load_data <= accept;
            frame_err <= 1'b0;
            if (accept) begin
                invert_adr <= {1'b0, rev};
                Re_i1      <= bit_width'(in_re);
                Im_i1      <= bit_width'(in_im);
            end
            case (state)
                IDLE: if (in_valid) begin
                    state <= LOAD;
                    cnt   <= SIZE'(1);
                    busy  <= 1'b1;
                end
                LOAD: if (!in_valid) begin
                    state     <= IDLE;
                    cnt       <= '0;
                    busy      <= 1'b0;
                    frame_err <= 1'b1;
                end else if (cnt == SIZE'(N-1)) begin
                    state <= WAIT_FFT;
                    cnt   <= '0;
                end else begin
                    cnt <= cnt + SIZE'(1);
                end
                WAIT_FFT: if (fft_done) begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bitrev_loader.sv
// tb_bitrev_loader: directed and random frames against a frame-level reference model
module tb_bitrev_loader;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [15:0] in_re = '0;
    logic [15:0] in_im = '0;
    logic        fft_done = 1'b0;
    logic        in_ready, load_data, busy, frame_err;
    logic [4:0]  invert_adr;
    logic [28:0] Re_i1, Im_i1;
    int total = 0;
    int bad = 0;
    int loaded = 0;
    bit full = 1'b0;
    logic        e_load = 1'b0, e_err = 1'b0, e_busy = 1'b0;
    logic [4:0]  e_adr = '0;
    logic [28:0] e_re = '0, e_im = '0;
    int tbl [16] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};

    bitrev_loader dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_re(in_re), .in_im(in_im),
        .in_ready(in_ready), .fft_done(fft_done), .load_data(load_data),
        .invert_adr(invert_adr), .Re_i1(Re_i1), .Im_i1(Im_i1), .busy(busy),
        .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    function automatic int brev(input int x);
        int r;
        r = 0;
        for (int b = 0; b < 4; b++) r = r * 2 + ((x >> b) & 1);
        return r;
    endfunction

    function automatic logic [28:0] sext(input logic [15:0] x);
        int v;
        v = int'($signed(x));
        return v[28:0];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("load_data", 32'(load_data), 32'(e_load));
        chk("frame_err", 32'(frame_err), 32'(e_err));
        chk("busy", 32'(busy), 32'(e_busy));
        chk("in_ready", 32'(in_ready), 32'(!full));
        chk("invert_adr", 32'(invert_adr), 32'(e_adr));
        chk("Re_i1", 32'(Re_i1), 32'(e_re));
        chk("Im_i1", 32'(Im_i1), 32'(e_im));
    endtask

    task automatic cyc(input logic v, input logic [15:0] re, input logic [15:0] im, input logic done);
        in_valid = v;
        in_re    = re;
        in_im    = im;
        fft_done = done;
        @(posedge clk);
        #1;
        e_load = 1'b0;
        e_err  = 1'b0;
        if (full) begin
            if (done) full = 1'b0;
        end else if (v) begin
            e_load = 1'b1;
            e_adr  = 5'(brev(loaded));
            e_re   = sext(re);
            e_im   = sext(im);
            loaded++;
            if (loaded == 16) begin
                full   = 1'b1;
                loaded = 0;
            end
        end else if (loaded > 0) begin
            e_err  = 1'b1;
            loaded = 0;
        end
        e_busy = full || loaded > 0;
        check_all();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        full = 1'b0; loaded = 0;
        e_load = 1'b0; e_err = 1'b0; e_busy = 1'b0;
        e_adr = '0; e_re = '0; e_im = '0;
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #3;
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
        cyc(1'b0, 16'h0, 16'h0, 1'b1);
        cyc(1'b0, 16'h0, 16'h0, 1'b1);
        for (int k = 0; k < 16; k++) begin
            cyc(1'b1, 16'(k), 16'(-k), k == 3);
            chk("adr_table", 32'(invert_adr), 32'(tbl[k]));
        end
        for (int k = 0; k < 10; k++) cyc(1'b1, 16'($urandom), 16'($urandom), 1'b0);
        cyc(1'b1, 16'h1234, 16'h4321, 1'b1);
        cyc(1'b1, 16'h8000, 16'h7fff, 1'b0);
        chk("sext_8000", 32'(Re_i1), 32'h1FFF8000);
        for (int k = 0; k < 4; k++) cyc(1'b1, 16'($urandom), 16'($urandom), 1'b0);
        cyc(1'b0, 16'h0, 16'h0, 1'b0);
        chk("gap_err", 32'(frame_err), 32'h1);
        for (int k = 0; k < 16; k++) cyc(1'b1, 16'($urandom), 16'($urandom), 1'b0);
        cyc(1'b0, 16'h0, 16'h0, 1'b0);
        cyc(1'b0, 16'h0, 16'h0, 1'b1);
        for (int k = 0; k < 7; k++) cyc(1'b1, 16'($urandom), 16'($urandom), 1'b0);
        do_reset();
        for (int k = 0; k < 16; k++) cyc(1'b1, 16'($urandom), 16'($urandom), 1'b0);
        cyc(1'b0, 16'h0, 16'h0, 1'b1);
        for (int k = 0; k < 400; k++)
            cyc($urandom_range(15, 0) != 0, 16'($urandom), 16'($urandom), $urandom_range(3, 0) == 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
